// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler feeding N byte requesters into one 12-bit UART frame transmitter
// Optional timeout watchdog on the WAIT state is built when TXS_TIMEOUT_EN is defined.
module uart_tx_sched #(
    parameter int NREQ    = 4,
    parameter int GRANT_W = 3,
    parameter int TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*8-1:0]    data_in,
    input  logic [1:0]           parity_type,
    input  logic                 tx_active,
    input  logic                 tx_done,
    output logic [11:0]          frame_out,
    output logic                 send,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      done,
    output logic [GRANT_W-1:0]   grant_id,
    output logic                 busy,
    output logic                 err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

    state_t               state_q, state_d;
    logic [11:0]          frame_d;
    logic [GRANT_W-1:0]   grant_d;
    logic                 send_d, busy_d;
    logic [NREQ-1:0]      ack_d, done_d;
    logic                 found;
    logic [GRANT_W-1:0]   pick;
    logic [7:0]           pick_byte;

    // Start bit low, data LSB-first from bit 10 down, parity slot, two stop bits.
    function automatic logic [11:0] build_frame(input logic [7:0] b, input logic [1:0] pt);
        logic [11:0] f;
        f = 12'h003;
        for (int i = 0; i < 8; i++) begin
            f[10-i] = b[i];
        end
        case (pt)
            2'b00:   f[2] = 1'b1;
            2'b10:   f[2] = ^b;
            default: f[2] = ~^b;
        endcase
        return f;
    endfunction

    // Search starts one past the last grant, so the last grant is checked last.
    always_comb begin
        int idx;
        found     = 1'b0;
        pick      = grant_id;
        idx       = 0;
        pick_byte = 8'h00;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(grant_id) + k) % NREQ;
            if (!found && |(req & (NREQ'(1) << idx))) begin
                found = 1'b1;
                pick  = GRANT_W'(idx);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (GRANT_W'(i) == pick) begin
                pick_byte = data_in[8*i +: 8];
            end
        end
    end

`ifdef TXS_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_d;
`endif

    always_comb begin
        state_d = state_q;
        frame_d = frame_out;
        grant_d = grant_id;
        send_d  = 1'b0;
        ack_d   = '0;
        done_d  = '0;
        busy_d  = busy;
`ifdef TXS_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    frame_d = build_frame(pick_byte, parity_type);
                    grant_d = pick;
                    ack_d   = NREQ'(1) << pick;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                send_d  = 1'b1;
                state_d = S_WAIT;
`ifdef TXS_TIMEOUT_EN
                cnt_d   = 8'h00;
`endif
            end
            S_WAIT: begin
                if (tx_done) begin
                    done_d  = NREQ'(1) << grant_id;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
`ifdef TXS_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q + 8'h01;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            frame_out <= 12'hFFF;
            grant_id  <= GRANT_W'(NREQ - 1);
            send      <= 1'b0;
            ack       <= '0;
            done      <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_out <= frame_d;
            grant_id  <= grant_d;
            send      <= send_d;
            ack       <= ack_d;
            done      <= done_d;
            busy      <= busy_d;
        end
    end

`ifdef TXS_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'h00;
            err   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err   <= err_d;
        end
    end
`else
    assign err = 1'b0;
`endif

    // Transmitter activity is informational only; completion is taken from tx_done.
    logic unused_cfg;
    assign unused_cfg = ^{tx_active, TIMEOUT[0]};

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed self-checking bench for uart_tx_sched (covers TXS_TIMEOUT_EN when defined)
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [1:0]  parity_type;
    logic        tx_active;
    logic        tx_done;
    logic [11:0] frame_out;
    logic        send;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic [2:0]  grant_id;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;
    int send_cnt = 0;
    int s0;

    logic [2:0]  rr_gnt [6];
    logic [11:0] rr_frm [6];

    uart_tx_sched #(.NREQ(4), .GRANT_W(3), .TIMEOUT(32)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
        .parity_type(parity_type), .tx_active(tx_active), .tx_done(tx_done),
        .frame_out(frame_out), .send(send), .ack(ack), .done(done),
        .grant_id(grant_id), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (send === 1'b1) send_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b0000; data_in = 32'h0; parity_type = 2'b00;
        tx_active = 1'b0; tx_done = 1'b0;
        rr_gnt[0] = 3'd0; rr_gnt[1] = 3'd1; rr_gnt[2] = 3'd3;
        rr_gnt[3] = 3'd0; rr_gnt[4] = 3'd1; rr_gnt[5] = 3'd3;
        rr_frm[0] = 12'h443; rr_frm[1] = 12'h223; rr_frm[2] = 12'h113;
        rr_frm[3] = 12'h443; rr_frm[4] = 12'h223; rr_frm[5] = 12'h113;
        repeat (2) @(negedge clk);
        chk("rst_frame", 32'(frame_out), 32'hFFF);
        chk("rst_send",  32'(send), 32'h0);
        chk("rst_ack",   32'(ack), 32'h0);
        chk("rst_done",  32'(done), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_err",   32'(err), 32'h0);
        chk("rst_grant", 32'(grant_id), 32'h3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ack", 32'(ack), 32'h0);

        // single request, even parity
        req = 4'b0001; data_in = 32'h000000A5; parity_type = 2'b10;
        @(negedge clk);
        chk("t1_ack",   32'(ack), 32'h1);
        chk("t1_grant", 32'(grant_id), 32'h0);
        chk("t1_busy",  32'(busy), 32'h1);
        chk("t1_frame", 32'(frame_out), 32'h52B);
        chk("t1_send0", 32'(send), 32'h0);
        req = 4'b0000;
        @(negedge clk);
        chk("t1_send",  32'(send), 32'h1);
        chk("t1_ack0",  32'(ack), 32'h0);
        chk("t1_hold",  32'(frame_out), 32'h52B);
        @(negedge clk);
        chk("t1_send_off", 32'(send), 32'h0);
        chk("t1_wait_busy", 32'(busy), 32'h1);
        chk("t1_wait_done", 32'(done), 32'h0);
        tx_done = 1'b1;
        @(negedge clk);
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_busy_clr", 32'(busy), 32'h0);
        tx_done = 1'b0;
        @(negedge clk);
        chk("t1_done_pulse", 32'(done), 32'h0);

        // odd parity, then parity changed mid-frame, then no parity
        req = 4'b0001; data_in = 32'h00000001; parity_type = 2'b01;
        @(negedge clk);
        chk("t2_odd_frame", 32'(frame_out), 32'h403);
        req = 4'b0000; parity_type = 2'b00;
        @(negedge clk);
        chk("t2_odd_send", 32'(send), 32'h1);
        chk("t2_odd_hold", 32'(frame_out), 32'h403);
        tx_done = 1'b1;
        @(negedge clk);
        chk("t2_odd_done", 32'(done), 32'h1);
        tx_done = 1'b0;
        req = 4'b0001;
        @(negedge clk);
        chk("t2_none_frame", 32'(frame_out), 32'h407);
        req = 4'b0000;
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        chk("t2_none_done", 32'(done), 32'h1);
        tx_done = 1'b0;

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // round-robin with req held continuously
        data_in = 32'h44332211; parity_type = 2'b10; req = 4'b1011;
        s0 = send_cnt;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_grant", i), 32'(grant_id), 32'(rr_gnt[i]));
            chk($sformatf("rr%0d_ack", i),   32'(ack), 32'(4'b0001 << rr_gnt[i]));
            chk($sformatf("rr%0d_frame", i), 32'(frame_out), 32'(rr_frm[i]));
            @(negedge clk);
            chk($sformatf("rr%0d_send", i), 32'(send), 32'h1);
            tx_done = 1'b1;
            @(negedge clk);
            chk($sformatf("rr%0d_done", i), 32'(done), 32'(4'b0001 << rr_gnt[i]));
            chk($sformatf("rr%0d_noack", i), 32'(ack), 32'h0);
            tx_done = 1'b0;
            if (i == 5) req = 4'b0000;
        end
        chk("rr_send_count", 32'(send_cnt - s0), 32'd6);

        // reset while waiting for tx_done
        req = 4'b0100;
        @(negedge clk);
        chk("t4_ack",   32'(ack), 32'h4);
        chk("t4_frame", 32'(frame_out), 32'h663);
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        chk("t4_waiting", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_frame", 32'(frame_out), 32'hFFF);
        chk("t4_rst_busy",  32'(busy), 32'h0);
        chk("t4_rst_grant", 32'(grant_id), 32'h3);
        chk("t4_rst_send",  32'(send), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tx_done = 1'b1;
        @(negedge clk);
        chk("stray_done", 32'(done), 32'h0);
        chk("stray_ack",  32'(ack), 32'h0);
        chk("stray_busy", 32'(busy), 32'h0);
        tx_done = 1'b0;
        req = 4'b0101;
        @(negedge clk);
        chk("t4_fresh_grant", 32'(grant_id), 32'h0);
        chk("t4_fresh_ack",   32'(ack), 32'h1);
        chk("t4_fresh_frame", 32'(frame_out), 32'h443);
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        chk("t4_no_done", 32'(done), 32'h0);
        tx_done = 1'b1;
        @(negedge clk);
        chk("t4_done", 32'(done), 32'h1);
        tx_done = 1'b0;

        // tx_done during LOAD is ignored
        req = 4'b1000;
        @(negedge clk);
        chk("t5_ack",   32'(ack), 32'h8);
        chk("t5_frame", 32'(frame_out), 32'h113);
        req = 4'b0000;
        tx_done = 1'b1;
        @(negedge clk);
        chk("t5_send", 32'(send), 32'h1);
        chk("t5_load_done", 32'(done), 32'h0);
        tx_done = 1'b0;
        @(negedge clk);
        chk("t5_still_busy", 32'(busy), 32'h1);
        chk("t5_still_nodone", 32'(done), 32'h0);
        tx_done = 1'b1;
        @(negedge clk);
        chk("t5_done", 32'(done), 32'h8);
        tx_done = 1'b0;

        // tx_done withheld
        req = 4'b0010;
        @(negedge clk);
        chk("t6_ack", 32'(ack), 32'h2);
        req = 4'b0001;
        @(negedge clk);
        chk("t6_send", 32'(send), 32'h1);
`ifdef TXS_TIMEOUT_EN
        repeat (31) @(negedge clk);
        chk("to_err_early", 32'(err), 32'h0);
        chk("to_busy_early", 32'(busy), 32'h1);
        @(negedge clk);
        chk("to_err", 32'(err), 32'h1);
        chk("to_busy_clr", 32'(busy), 32'h0);
        chk("to_no_done", 32'(done), 32'h0);
        @(negedge clk);
        chk("to_err_pulse", 32'(err), 32'h0);
        chk("to_next_grant", 32'(grant_id), 32'h0);
        chk("to_next_ack", 32'(ack), 32'h1);
        req = 4'b0000;
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        chk("to_next_done", 32'(done), 32'h1);
        tx_done = 1'b0;
`else
        repeat (40) @(negedge clk);
        chk("nto_busy", 32'(busy), 32'h1);
        chk("nto_err",  32'(err), 32'h0);
        chk("nto_done", 32'(done), 32'h0);
        tx_done = 1'b1;
        @(negedge clk);
        chk("nto_late_done", 32'(done), 32'h2);
        tx_done = 1'b0;
        @(negedge clk);
        chk("nto_next_grant", 32'(grant_id), 32'h0);
        chk("nto_next_ack", 32'(ack), 32'h1);
        req = 4'b0000;
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        chk("nto_next_done", 32'(done), 32'h1);
        tx_done = 1'b0;
`endif
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
